// File: rtl/dm_axi_master_if.sv
// Single-beat AXI4 link between the data-memory bus adapter (master) and the
// memory-side slave. All five channels are grouped here.
interface dm_axi_master_if #(
    parameter int ID_WIDTH = 4
);
    logic [ID_WIDTH-1:0] ARID;
    logic [31:0]         ARADDR;
    logic [7:0]          ARLEN;
    logic [2:0]          ARSIZE;
    logic [1:0]          ARBURST;
    logic                ARVALID;
    logic                ARREADY;

    logic [ID_WIDTH-1:0] RID;
    logic [31:0]         RDATA;
    logic [1:0]          RRESP;
    logic                RLAST;
    logic                RVALID;
    logic                RREADY;

    logic [ID_WIDTH-1:0] AWID;
    logic [31:0]         AWADDR;
    logic [7:0]          AWLEN;
    logic [2:0]          AWSIZE;
    logic [1:0]          AWBURST;
    logic                AWVALID;
    logic                AWREADY;

    logic [31:0]         WDATA;
    logic [3:0]          WSTRB;
    logic                WLAST;
    logic                WVALID;
    logic                WREADY;

    logic [ID_WIDTH-1:0] BID;
    logic [1:0]          BRESP;
    logic                BVALID;
    logic                BREADY;

    modport master (
        output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        input  ARREADY,
        input  RID, RDATA, RRESP, RLAST, RVALID,
        output RREADY,
        output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        input  AWREADY,
        output WDATA, WSTRB, WLAST, WVALID,
        input  WREADY,
        input  BID, BRESP, BVALID,
        output BREADY
    );

    modport slave (
        input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
        output ARREADY,
        output RID, RDATA, RRESP, RLAST, RVALID,
        input  RREADY,
        input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
        output AWREADY,
        input  WDATA, WSTRB, WLAST, WVALID,
        output WREADY,
        output BID, BRESP, BVALID,
        input  BREADY
    );
endinterface

// File: rtl/dm_axi_master.sv
// Data-memory bus adapter: turns each MEM-stage DM request into one single-beat
// AXI4 read or write and freezes the pipeline until it completes.
module dm_axi_master #(
    parameter int ID_WIDTH = 4,
    parameter int AXI_ID   = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_DM_CS,
    input  logic            i_DM_OE,
    input  logic [3:0]      i_DM_WEB,
    input  logic [31:0]     i_DM_addr,
    input  logic [31:0]     i_DM_DI,
    output logic [31:0]     o_DM_DO,
    output logic            o_mem_stall,
    output logic            o_bus_err,
    dm_axi_master_if.master io_axi
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_ADDR,
        S_RD_DATA,
        S_WR_REQ,
        S_WR_RESP,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] r_do;
    logic        r_aw_done;
    logic        r_w_done;
    logic        r_err;

    logic        w_wr_req;
    logic        w_rd_req;
    logic        w_arvalid;
    logic        w_rready;
    logic        w_awvalid;
    logic        w_wvalid;
    logic        w_bready;
    logic        w_unused;

    // A write wins when a store and a load are both flagged.
    assign w_wr_req = i_DM_CS & ~(&i_DM_WEB);
    assign w_rd_req = i_DM_CS & i_DM_OE & ~w_wr_req;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        // NOTE: every output gets a default first, so no path can infer a latch.
        w_next      = r_state;
        w_arvalid   = 1'b0;
        w_rready    = 1'b0;
        w_awvalid   = 1'b0;
        w_wvalid    = 1'b0;
        w_bready    = 1'b0;
        o_mem_stall = 1'b0;
        o_bus_err   = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_mem_stall = w_wr_req | w_rd_req;
                if (w_wr_req)      w_next = S_WR_REQ;
                else if (w_rd_req) w_next = S_RD_ADDR;
            end
            S_RD_ADDR: begin
                o_mem_stall = 1'b1;
                w_arvalid   = 1'b1;
                if (io_axi.ARREADY) w_next = S_RD_DATA;
            end
            S_RD_DATA: begin
                o_mem_stall = 1'b1;
                w_rready    = 1'b1;
                if (io_axi.RVALID) w_next = S_DONE;
            end
            S_WR_REQ: begin
                // AW and W retire independently; leave once both have (or do now).
                o_mem_stall = 1'b1;
                w_awvalid   = ~r_aw_done;
                w_wvalid    = ~r_w_done;
                if ((r_aw_done | io_axi.AWREADY) & (r_w_done | io_axi.WREADY))
                    w_next = S_WR_RESP;
            end
            S_WR_RESP: begin
                o_mem_stall = 1'b1;
                w_bready    = 1'b1;
                if (io_axi.BVALID) w_next = S_DONE;
            end
            S_DONE: begin
                o_bus_err = r_err;
                w_next    = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_do      <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_req | w_rd_req) begin
                        r_addr    <= {i_DM_addr[31:2], 2'b00};
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                    end
                    if (w_wr_req) begin
                        r_wdata <= i_DM_DI;
                        r_wstrb <= ~i_DM_WEB;
                    end
                end
                S_RD_DATA: begin
                    if (io_axi.RVALID) begin
                        r_do  <= io_axi.RDATA;
                        r_err <= |io_axi.RRESP;
                    end
                end
                S_WR_REQ: begin
                    if (io_axi.AWREADY) r_aw_done <= 1'b1;
                    if (io_axi.WREADY)  r_w_done  <= 1'b1;
                end
                S_WR_RESP: begin
                    if (io_axi.BVALID) r_err <= |io_axi.BRESP;
                end
                default: ;
            endcase
        end
    end

    assign o_DM_DO = r_do;

    assign io_axi.ARID    = ID_WIDTH'(AXI_ID);
    assign io_axi.ARADDR  = r_addr;
    assign io_axi.ARLEN   = 8'd0;
    assign io_axi.ARSIZE  = 3'b010;
    assign io_axi.ARBURST = 2'b01;
    assign io_axi.ARVALID = w_arvalid;
    assign io_axi.RREADY  = w_rready;

    assign io_axi.AWID    = ID_WIDTH'(AXI_ID);
    assign io_axi.AWADDR  = r_addr;
    assign io_axi.AWLEN   = 8'd0;
    assign io_axi.AWSIZE  = 3'b010;
    assign io_axi.AWBURST = 2'b01;
    assign io_axi.AWVALID = w_awvalid;

    assign io_axi.WDATA   = r_wdata;
    assign io_axi.WSTRB   = r_wstrb;
    assign io_axi.WLAST   = 1'b1;
    assign io_axi.WVALID  = w_wvalid;
    assign io_axi.BREADY  = w_bready;

    // Single outstanding transaction with a fixed ID: response IDs and RLAST carry no information.
    assign w_unused = ^{io_axi.RID, io_axi.RLAST, io_axi.BID, i_DM_addr[1:0]};
endmodule
